// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, single-word memory reads, instruction register with valid/ready
// Optional read-timeout/reissue logic is enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch #(
   parameter int ADDR_WIDTH  = 5,
   parameter int REG_BIT_CNT = 3,
   parameter int DATA_WIDTH  = 16,
   parameter int INSTR_WIDTH = ADDR_WIDTH + REG_BIT_CNT + DATA_WIDTH,
   parameter int PC_WIDTH    = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [PC_WIDTH-1:0]    mem_addr,
   output logic                   mem_req,
   input  logic                   mem_valid,
   input  logic [INSTR_WIDTH-1:0] mem_data,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   input  logic                   jump,
   input  logic [PC_WIDTH-1:0]    jump_addr,
   input  logic                   halt,
   output logic [PC_WIDTH-1:0]    pc,
   output logic                   fetch_timeout
);

   typedef enum logic [2:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DRAIN,
      S_HALTED
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [PC_WIDTH-1:0]    pc_nxt;
   logic [INSTR_WIDTH-1:0] instr_nxt;
   logic                   instr_valid_nxt;
   logic                   wait_expired;

   // The request strobe is held off while reset is asserted.
   assign mem_req  = (state == S_REQ) && !rst;
   assign mem_addr = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_REQ;
         pc          <= '0;
         instr       <= '0;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         instr       <= instr_nxt;
         instr_valid <= instr_valid_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      instr_nxt       = instr;
      instr_valid_nxt = instr_valid;
      case (state)
         S_REQ: begin
            state_nxt = jump ? S_DRAIN : S_WAIT;
         end
         S_WAIT: begin
            if (jump) begin
               state_nxt = S_DRAIN;
            end else if (mem_valid) begin
               instr_nxt       = mem_data;
               instr_valid_nxt = 1'b1;
               pc_nxt          = pc + 1'b1;
               state_nxt       = S_HOLD;
            end else if (wait_expired) begin
               state_nxt = S_REQ;
            end
         end
         S_HOLD: begin
            if (jump) begin
               instr_valid_nxt = 1'b0;
               state_nxt       = S_REQ;
            end else if (instr_ready) begin
               instr_valid_nxt = 1'b0;
               state_nxt       = halt ? S_HALTED : S_REQ;
            end
         end
         S_DRAIN: begin
            // A jump while draining keeps waiting for the old response to retire.
            if (!jump && (mem_valid || wait_expired)) begin
               state_nxt = S_REQ;
            end
         end
         S_HALTED: begin
            instr_valid_nxt = 1'b0;
            if (jump) begin
               state_nxt = S_REQ;
            end
         end
         default: begin
            state_nxt = S_REQ;
         end
      endcase
      if (jump) begin
         pc_nxt = jump_addr;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   logic [3:0] wait_cnt;

   // Expires in the cycle the counter would reach 15, so the reissue lands 16 cycles after REQ.
   assign wait_expired = ((state == S_WAIT) || (state == S_DRAIN)) && !jump && !mem_valid &&
                         (wait_cnt == 4'd14);

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt      <= 4'd0;
         fetch_timeout <= 1'b0;
      end else begin
         fetch_timeout <= wait_expired;
         wait_cnt      <= (state_nxt != state) ? 4'd0 : wait_cnt + 4'd1;
      end
   end
`else
   assign wait_expired  = 1'b0;
   assign fetch_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed bench for instruction_fetch with a fetch-order reference model
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  mem_addr;
   logic        mem_req;
   logic        mem_valid = 1'b0;
   logic [23:0] mem_data = '0;
   logic [23:0] instr;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        jump = 1'b0;
   logic [7:0]  jump_addr = '0;
   logic        halt = 1'b0;
   logic [7:0]  pc;
   logic        fetch_timeout;

   instruction_fetch dut (
      .clk           (clk),
      .rst           (rst),
      .mem_addr      (mem_addr),
      .mem_req       (mem_req),
      .mem_valid     (mem_valid),
      .mem_data      (mem_data),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .jump          (jump),
      .jump_addr     (jump_addr),
      .halt          (halt),
      .pc            (pc),
      .fetch_timeout (fetch_timeout)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // memory responder: one outstanding read, a new request replaces it
   int         cyc = -1;
   int         mem_lat = 1;
   bit         mem_silent = 1'b0;
   bit         pend = 1'b0;
   int         pend_cyc = 0;
   logic [7:0] pend_addr = '0;
   int         req_cnt = 0;
   int         vld_cnt = 0;
   logic [23:0] s_instr;
   logic [7:0]  s_addr, s_pc;
   logic        s_req, s_valid, s_to;

   task automatic cycle(input logic rdy, input logic jmp, input logic [7:0] ja, input logic hlt);
      @(negedge clk);
      rst = 1'b0;
      #1;
      cyc++;
      s_instr = instr; s_addr = mem_addr; s_pc = pc;
      s_req = mem_req; s_valid = instr_valid; s_to = fetch_timeout;
      if (mem_req) req_cnt++;
      if (instr_valid) vld_cnt++;
      instr_ready = rdy; jump = jmp; jump_addr = ja; halt = hlt;
      if (pend && pend_cyc == cyc && !mem_silent) begin
         mem_valid = 1'b1;
         mem_data  = 24'hA00000 | {16'h0, pend_addr};
         pend      = 1'b0;
      end else begin
         mem_valid = 1'b0;
         mem_data  = 24'h5A5A5A;
      end
      if (mem_req) begin
         pend      = 1'b1;
         pend_cyc  = cyc + mem_lat;
         pend_addr = mem_addr;
      end
   endtask

   task automatic run(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cycle(rdy, 1'b0, 8'h00, 1'b0);
   endtask

   // Reference model: the program is the sequence of addresses exp_pc, exp_pc+1, ...
   // restarted at every jump target; delivered words must follow it exactly.
   bit          model_on = 1'b0;
   logic [7:0]  exp_pc = 8'h00;
   bit          halted_m = 1'b0;
   bit          prev_hold = 1'b0;
   bit          prev_hs = 1'b0;
   logic [23:0] prev_instr = '0;

   always @(negedge clk) if (model_on) begin
      #2;
      if (mem_req) chk("req_addr", 32'(mem_addr), 32'(exp_pc));
      if (halted_m) begin
         chk("halted_req", 32'(mem_req), 32'd0);
         chk("halted_valid", 32'(instr_valid), 32'd0);
      end
      if (prev_hold) begin
         chk("stall_valid", 32'(instr_valid), 32'd1);
         chk("stall_instr", 32'(instr), 32'(prev_instr));
      end
      if (prev_hs) chk("hs_drop", 32'(instr_valid), 32'd0);
`ifndef FETCH_TIMEOUT_EN
      chk("no_timeout", 32'(fetch_timeout), 32'd0);
`endif
      prev_hold  = instr_valid && !instr_ready && !jump;
      prev_hs    = instr_valid && instr_ready;
      prev_instr = instr;
      if (instr_valid && instr_ready) begin
         chk("deliver", 32'(instr), 32'hA00000 | 32'(exp_pc));
         exp_pc = exp_pc + 8'd1;
         if (halt && !jump) halted_m = 1'b1;
      end
      if (jump) begin
         exp_pc   = jump_addr;
         halted_m = 1'b0;
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_timeout", 32'(fetch_timeout), 32'd0);
      model_on = 1'b1;

      // c0..c8: words 0,1,2 at cycles 2,5,8
      run(3, 1'b1);
      chk("w0_instr", 32'(s_instr), 32'hA00000);
      chk("w0_valid", 32'(s_valid), 32'd1);
      run(3, 1'b1);
      chk("w1_instr", 32'(s_instr), 32'hA00001);
      run(2, 1'b1);
      req_cnt = 0;
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      chk("w2_instr", 32'(s_instr), 32'hA00002);
      chk("w2_pc", 32'(s_pc), 32'd3);
      // c9..c17: stall
      run(9, 1'b0);
      chk("stall_end_instr", 32'(s_instr), 32'hA00002);
      chk("stall_end_valid", 32'(s_valid), 32'd1);
      chk("stall_no_req", 32'(req_cnt), 32'd0);
      chk("stall_pc", 32'(s_pc), 32'd3);
      run(1, 1'b1);
      // c19: request for word 3, response two cycles later, jump lands in between
      mem_lat = 2;
      run(1, 1'b1);
      chk("req3", 32'({s_req, s_addr}), 32'h103);
      cycle(1'b1, 1'b1, 8'h40, 1'b0);
      run(2, 1'b1);
      chk("jump_req", 32'({s_req, s_addr}), 32'h140);
      run(2, 1'b1);
      mem_lat = 1;
      // c25: jump together with a handshake
      cycle(1'b1, 1'b1, 8'hFF, 1'b0);
      chk("jump_instr", 32'(s_instr), 32'hA00040);
      chk("jump_pc", 32'(s_pc), 32'h41);
      run(1, 1'b1);
      chk("ff_req", 32'({s_req, s_addr}), 32'h1FF);
      run(2, 1'b1);
      chk("ff_instr", 32'(s_instr), 32'hA000FF);
      chk("wrap_pc", 32'(s_pc), 32'd0);
      run(1, 1'b1);
      chk("wrap_req", 32'({s_req, s_addr}), 32'h100);
      run(1, 1'b1);
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      chk("halt_instr", 32'(s_instr), 32'hA00000);
      req_cnt = 0;
      vld_cnt = 0;
      run(10, 1'b1);
      chk("halted_no_req", 32'(req_cnt), 32'd0);
      chk("halted_no_valid", 32'(vld_cnt), 32'd0);
      cycle(1'b1, 1'b1, 8'h10, 1'b0);
      run(1, 1'b1);
      chk("resume_req", 32'({s_req, s_addr}), 32'h110);
      run(2, 1'b1);
      chk("resume_instr", 32'(s_instr), 32'hA00010);
      // silent memory from here on
      mem_silent = 1'b1;
      run(1, 1'b1);
      chk("silent_req", 32'({s_req, s_addr}), 32'h111);
      req_cnt = 0;
`ifdef FETCH_TIMEOUT_EN
      run(15, 1'b1);
      chk("to_quiet", 32'(req_cnt), 32'd0);
      run(1, 1'b1);
      chk("to_reissue", 32'({s_req, s_addr}), 32'h111);
      chk("to_pulse", 32'(s_to), 32'd1);
`else
      run(20, 1'b1);
      chk("silent_wait", 32'(req_cnt), 32'd0);
`endif
      @(negedge clk);
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
